// File: rtl/sub_bytes_seq.sv
// AES forward SubBytes over a 128-bit state, one 32-bit word per cycle.
// Four shared S-box lookups are reused over four cycles, with a valid/ready handshake on each side.

module sub_bytes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  // FIPS-197 forward S-box. Entry 0x00 occupies the top byte, so entry x sits at bit (255-x)*8.
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = TABLE[{~a, 3'b000} +: 8];
endmodule

module sub_bytes_seq #(
  parameter int BYTE   = 8,
  parameter int DWORD  = 32,
  parameter int LENGTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] state_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] state_out,
  output logic              busy
);
  localparam int LANES = DWORD / BYTE;
  localparam int WORDS = LENGTH / DWORD;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int IDX_W = $clog2(LENGTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LENGTH-1:0] in_reg;
  logic [LENGTH-1:0] res_reg;
  logic [IDX_W-1:0]  base;
  logic [DWORD-1:0]  word_in;
  logic [DWORD-1:0]  word_out;

  // The same bit offset selects the source word and the destination word in the result.
  assign base    = IDX_W'(cnt) << $clog2(DWORD);
  assign word_in = in_reg[base +: DWORD];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sub_bytes_sbox u_sbox (
      .a (word_in[g*BYTE +: BYTE]),
      .s (word_out[g*BYTE +: BYTE])
    );
  end

  // NOTE: every state element is assigned with <= so that all of them update together on the edge.
  // The data registers are cleared on reset, not only the control state, so a reset never leaves
  // an older result on state_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      in_reg  <= '0;
      res_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg <= state_in;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          res_reg[base +: DWORD] <= word_out;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags are decoded straight from the state register, so they have no combinational input paths.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign state_out = res_reg;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq. A scoreboard queue holds the expected results.
// The reference S-box is computed from GF(2^8) inversion and the affine transform.

module tb_sub_bytes_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   model_sbox [256];

  sub_bytes_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_model();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      model_sbox[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = model_sbox[d[8*i +: 8]];
    return r;
  endfunction

  // Scoreboard: pop and compare on every cycle where the output handshake completes.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_int("sb_unexpected_output", 1, 0);
      end else begin
        check("sb_result", state_out, exp_q.pop_front());
      end
    end
  end

  // Waits for in_ready, then drives d for one accepting edge. The state_in value that follows is random.
  task automatic accept(input logic [127:0] d);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check_bit("accept_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    state_in = d;
    @(posedge clk); #1;
    exp_q.push_back(ref_sub(d));
    in_valid = 1'b0;
    state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Called #1 after the accepting edge. Counts edges until out_valid rises.
  task automatic wait_done(input string tag);
    int edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check_int(tag, edges, 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] x;
    logic [127:0] d;
    int t1;
    int t2;

    build_model();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    #3;
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check("rst_state_out", state_out, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_bit("post_rst_in_ready", in_ready, 1'b1);

    // All-zero state
    out_ready = 1'b1;
    accept(128'h0);
    check_bit("zero_busy_run", busy, 1'b1);
    check_bit("zero_in_ready_run", in_ready, 1'b0);
    wait_done("zero_latency");
    check("zero_const", state_out, 128'h63636363636363636363636363636363);
    @(posedge clk); #1;
    check_bit("zero_back_idle", in_ready, 1'b1);
    check_bit("zero_busy_idle", busy, 1'b0);
    check_bit("zero_out_valid_low", out_valid, 1'b0);
    check("zero_hold", state_out, 128'h63636363636363636363636363636363);

    // Vector covering the full byte range
    accept(128'h00112233445566778899aabbccddeeff);
    wait_done("full_latency");
    check("full_const", state_out, 128'h638293c31bfc33f5c4eeacea4bc12816);
    @(posedge clk); #1;

    // Backpressure, with in_valid pulses arriving while DONE holds
    out_ready = 1'b0;
    x = 128'h0123456789abcdeffedcba9876543210;
    accept(x);
    wait_done("bp_latency");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      state_in = '1;
      check_bit("bp_out_valid", out_valid, 1'b1);
      check_bit("bp_in_ready", in_ready, 1'b0);
      check("bp_state_out", state_out, ref_sub(x));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_bit("bp_release_idle", in_ready, 1'b1);
    check_bit("bp_release_out_valid", out_valid, 1'b0);
    check("bp_release_hold", state_out, ref_sub(x));

    // Reset partway through RUN
    accept({16{8'h53}});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check("midrst_state_out", state_out, 128'h0);
    check_bit("midrst_busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_bit("midrst_in_ready", in_ready, 1'b1);
    accept({16{8'h53}});
    wait_done("midrst_latency");
    check("midrst_const", state_out, {16{8'hed}});
    @(posedge clk); #1;

    // Back-to-back states with in_valid held high
    in_valid = 1'b1;
    state_in = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
    @(posedge clk); #1;
    exp_q.push_back(ref_sub(128'hdeadbeef_cafef00d_12345678_9abcdef0));
    state_in = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    wait_done("b2b_latency_a");
    t1 = cyc;
    @(posedge clk); #1;
    check_bit("b2b_idle_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    exp_q.push_back(ref_sub(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0));
    in_valid = 1'b0;
    check_bit("b2b_b_accepted", busy, 1'b1);
    wait_done("b2b_latency_b");
    t2 = cyc;
    check_int("b2b_spacing", t2 - t1, 6);
    @(posedge clk); #1;

    // Every byte value passes through every byte lane
    for (int k = 0; k < 256; k++) begin
      for (int j = 0; j < 16; j++) d[8*j +: 8] = 8'(k + 17 * j);
      accept(d);
      wait_done("exh_latency");
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check_int("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
